decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be:
- XLEN, default 64: immediate output width.
- PC_W, default 64: program-counter width.
- CNT_W, default 16: decoded-instruction counter width.
REQ-002 Ports SHALL be:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard held instruction; block acceptance this cycle.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_inst  in  32  LEGv8 instruction word.
- in_pc  in  PC_W  address of in_inst.
- out_valid  out  1  decoded record valid.
- out_ready  in  1  downstream accepts.
- out_fmt  out  3  format: 0=R, 1=I, 2=D, 3=CB, 4=B, 7=illegal.
- out_opcode  out  11  in_inst[31:21] as captured.
- out_rd  out  5  destination / Rt field.
- out_rn  out  5  first source field.
- out_rm  out  5  second source field.
- out_imm  out  XLEN  extended immediate.
- out_target  out  PC_W  branch target.
- out_illegal  out  1  no encoding matched.
- dec_count  out  CNT_W  count of legal instructions delivered.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-004 Decode SHALL recognise the following, matching on the listed bits; all other words SHALL be illegal:
- inst[31:21]: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (R); STUR 11111000000, LDUR 11111000010 (D).
- inst[31:22]: ADDI 1001000100, SUBI 1101000100 (I).
- inst[31:24]: CBZ 10110100, CBNZ 10110101 (CB).
- inst[31:26]: B 000101 (B).
REQ-005 Field extraction SHALL be:
- rd = inst[4:0] for R, I, D, CB; 0 for B.
- rn = inst[9:5] for R, I, D; 0 for CB, B.
- rm = inst[20:16] for R; 0 otherwise.
REQ-006 Immediates SHALL be:
- I: inst[21:10] zero-extended to XLEN.
- D: inst[20:12] sign-extended.
- CB: inst[23:5] sign-extended, then shifted left 2.
- B: inst[25:0] sign-extended, then shifted left 2.
- R: 0.
REQ-007 out_target SHALL be (in_pc + out_imm) modulo 2^PC_W for CB and B, and 0 otherwise; no overflow flag.
REQ-008 Illegal words SHALL give out_fmt=7 and out_illegal=1, and SHALL zero out_rd, out_rn, out_rm, out_imm and out_target; the record is still delivered.
REQ-009 The stage SHALL be a single registered entry with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-010 in_ready SHALL equal !flush && (!out_valid || out_ready), computed combinationally.
REQ-011 Acceptance (in_valid && in_ready) SHALL register the decoded record, setting out_valid=1 on the next edge; latency is exactly 1 cycle.
REQ-012 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-013 An output handshake with a simultaneous acceptance SHALL replace the record with no bubble (full throughput).
REQ-014 An output handshake without acceptance SHALL clear out_valid.
REQ-015 flush SHALL clear out_valid on the next edge, dominate any handshake that cycle, and not change dec_count.
REQ-016 dec_count SHALL increment by 1 on each output handshake with out_illegal=0, and SHALL saturate at 2^CNT_W-1.

Reset
REQ-017 While rst_n=0, the stage SHALL immediately reach the following state, independent of clk, including mid-transfer:
- out_valid=0 and dec_count=0.
- all out_* fields 0.
REQ-018 While rst_n=0, in_ready SHALL be 0; the first acceptance SHALL occur on the first rising edge after rst_n rises.

Verification
REQ-019 ADD: inst=0x8B020023 accepted, out_ready=1 -> next cycle out_fmt=0, rd=3, rn=1, rm=2, imm=0, dec_count 0->1.
REQ-020 CBZ: inst=0xB4FFFFC5, pc=0x100 -> out_fmt=3, rd=5, imm=-8, target=0xF8.
REQ-021 Backpressure: out_ready=0 for 3 cycles with a second word offered -> in_ready=0, outputs unchanged, dec_count unchanged; out_ready=1 -> second word appears the cycle after.
REQ-022 Flush: flush=1 while FULL and in_valid=1 -> out_valid=0 next cycle, input not accepted, dec_count unchanged.
REQ-023 Illegal: inst=0x00000000 -> out_illegal=1, out_fmt=7, all fields 0, dec_count unchanged after handshake.
REQ-024 Saturation and reset: with CNT_W=2, 5 legal handshakes -> dec_count=3; asserting rst_n=0 between clock edges -> out_valid=0 and dec_count=0 immediately.

Source files
------------

// File: rtl/decode_if.sv
// Handshake bundle for the LEGv8 decode stage: upstream instruction channel,
// downstream decoded-record channel and the flush control.
interface decode_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 64
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      out_fmt;
  logic [10:0]     out_opcode;
  logic [4:0]      out_rd;
  logic [4:0]      out_rn;
  logic [4:0]      out_rm;
  logic [XLEN-1:0] out_imm;
  logic [PC_W-1:0] out_target;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_fmt, out_opcode, out_rd, out_rn, out_rm,
           out_imm, out_target, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_fmt, out_opcode, out_rd, out_rn, out_rm,
           out_imm, out_target, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Single-entry registered LEGv8 decode stage: decodes the offered word
// combinationally and holds one decoded record under a valid/ready handshake.
module decode_stage #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  decode_if.slave          bus,
  output logic [CNT_W-1:0] dec_count
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_D   = 3'd2,
    FMT_CB  = 3'd3,
    FMT_B   = 3'd4,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef enum logic {EMPTY, FULL} state_e;

  typedef struct packed {
    fmt_e            fmt;
    logic [10:0]     opcode;
    logic [4:0]      rd;
    logic [4:0]      rn;
    logic [4:0]      rm;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] target;
    logic            illegal;
  } rec_t;

  state_e      state_q, state_d;
  rec_t        rec_q, dec;
  logic [31:0] inst;
  logic [PC_W-1:0] br_off;
  logic        out_valid;
  logic        accept;
  logic        fire;

  assign inst = bus.in_inst;

  // Decode of the word currently offered upstream.
  // NOTE: every field gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    dec         = '0;
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    dec.opcode  = inst[31:21];
    br_off      = '0;

    casez (inst[31:21])
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: dec.fmt = FMT_R;
      11'b11111000000, 11'b11111000010: dec.fmt = FMT_D;
      11'b1001000100?, 11'b1101000100?: dec.fmt = FMT_I;
      11'b1011010????:                  dec.fmt = FMT_CB;
      11'b000101?????:                  dec.fmt = FMT_B;
      default:                          dec.fmt = FMT_ILL;
    endcase

    case (dec.fmt)
      FMT_R: begin
        dec.illegal = 1'b0;
        dec.rd      = inst[4:0];
        dec.rn      = inst[9:5];
        dec.rm      = inst[20:16];
      end
      FMT_I: begin
        dec.illegal = 1'b0;
        dec.rd      = inst[4:0];
        dec.rn      = inst[9:5];
        dec.imm     = {{(XLEN-12){1'b0}}, inst[21:10]};
      end
      FMT_D: begin
        dec.illegal = 1'b0;
        dec.rd      = inst[4:0];
        dec.rn      = inst[9:5];
        dec.imm     = {{(XLEN-9){inst[20]}}, inst[20:12]};
      end
      FMT_CB: begin
        dec.illegal = 1'b0;
        dec.rd      = inst[4:0];
        dec.imm     = {{(XLEN-21){inst[23]}}, inst[23:5], 2'b00};
        br_off      = {{(PC_W-21){inst[23]}}, inst[23:5], 2'b00};
        dec.target  = bus.in_pc + br_off;
      end
      FMT_B: begin
        dec.illegal = 1'b0;
        dec.imm     = {{(XLEN-28){inst[25]}}, inst[25:0], 2'b00};
        br_off      = {{(PC_W-28){inst[25]}}, inst[25:0], 2'b00};
        dec.target  = bus.in_pc + br_off;
      end
      default: ;
    endcase
  end

  // Ready is gated by reset so nothing can be taken while the stage is held.
  assign out_valid    = (state_q == FULL);
  assign bus.in_ready = rst_n && !bus.flush && (!out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    state_d = state_q;
    if (bus.flush)   state_d = EMPTY;
    else if (accept) state_d = FULL;
    else if (fire)   state_d = EMPTY;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: the record register is reset as well, because the outputs must read
  // zero during reset rather than whatever was last captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rec_q <= '0;
    else if (accept) rec_q <= dec;
  end

  // Flush suppresses fire, so a discarded record never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dec_count <= '0;
    else if (fire && !rec_q.illegal && (dec_count != {CNT_W{1'b1}}))
      dec_count <= dec_count + 1'b1;
  end

  assign bus.out_valid   = out_valid;
  assign bus.out_fmt     = rec_q.fmt;
  assign bus.out_opcode  = rec_q.opcode;
  assign bus.out_rd      = rec_q.rd;
  assign bus.out_rn      = rec_q.rn;
  assign bus.out_rm      = rec_q.rm;
  assign bus.out_imm     = rec_q.imm;
  assign bus.out_target  = rec_q.target;
  assign bus.out_illegal = rec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a reference decoder feeds a scoreboard on
// each acceptance; the held record is compared after every clock edge.
module tb_decode_stage;

  localparam int CNT_MAX = 3;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] imm;
    logic [63:0] target;
    logic        illegal;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dec_count;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       sb[$];
  logic       exp_valid = 1'b0;
  int         exp_cnt = 0;

  always #5 clk = ~clk;

  decode_if #(.XLEN(64), .PC_W(64)) b ();

  decode_stage #(.XLEN(64), .PC_W(64), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (b),
    .dec_count (dec_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
    exp_t e;
    logic signed [63:0] off;
    e         = '0;
    e.opcode  = w[31:21];
    e.fmt     = 3'd7;
    e.illegal = 1'b1;
    off       = '0;
    if (w[31:21] == 11'b10001011000 || w[31:21] == 11'b11001011000 ||
        w[31:21] == 11'b10001010000 || w[31:21] == 11'b10101010000) begin
      e.fmt = 3'd0; e.illegal = 1'b0;
      e.rd = w[4:0]; e.rn = w[9:5]; e.rm = w[20:16];
    end else if (w[31:21] == 11'b11111000000 || w[31:21] == 11'b11111000010) begin
      e.fmt = 3'd2; e.illegal = 1'b0;
      e.rd = w[4:0]; e.rn = w[9:5];
      off = 64'($signed(w[20:12]));
      e.imm = off;
    end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
      e.fmt = 3'd1; e.illegal = 1'b0;
      e.rd = w[4:0]; e.rn = w[9:5];
      e.imm = {52'd0, w[21:10]};
    end else if (w[31:24] == 8'b10110100 || w[31:24] == 8'b10110101) begin
      e.fmt = 3'd3; e.illegal = 1'b0;
      e.rd = w[4:0];
      off = 64'($signed(w[23:5]));
      off = off <<< 2;
      e.imm = off;
      e.target = pc + off;
    end else if (w[31:26] == 6'b000101) begin
      e.fmt = 3'd4; e.illegal = 1'b0;
      off = 64'($signed(w[25:0]));
      off = off <<< 2;
      e.imm = off;
      e.target = pc + off;
    end
    return e;
  endfunction

  task automatic check_rec(input exp_t e);
    check("out_fmt",     64'(b.out_fmt),     64'(e.fmt));
    check("out_opcode",  64'(b.out_opcode),  64'(e.opcode));
    check("out_rd",      64'(b.out_rd),      64'(e.rd));
    check("out_rn",      64'(b.out_rn),      64'(e.rn));
    check("out_rm",      64'(b.out_rm),      64'(e.rm));
    check("out_imm",     b.out_imm,          e.imm);
    check("out_target",  b.out_target,       e.target);
    check("out_illegal", 64'(b.out_illegal), 64'(e.illegal));
  endtask

  // One clock: predict ready/acceptance before the edge, update the model at
  // the edge, compare state and held record just after it.
  task automatic tick();
    logic exp_rdy, acc, fire;
    exp_t nxt, popped;
    @(negedge clk);
    exp_rdy = rst_n && !b.flush && (!exp_valid || b.out_ready);
    check("in_ready", 64'(b.in_ready), 64'(exp_rdy));
    acc  = b.in_valid && exp_rdy;
    fire = exp_valid && b.out_ready && !b.flush;
    nxt  = model(b.in_inst, b.in_pc);
    @(posedge clk);
    if (!rst_n) begin
      exp_valid = 1'b0; exp_cnt = 0; sb.delete();
    end else if (b.flush) begin
      if (exp_valid) popped = sb.pop_front();
      exp_valid = 1'b0;
    end else begin
      if (fire) begin
        popped = sb.pop_front();
        if (!popped.illegal && exp_cnt != CNT_MAX) exp_cnt++;
      end
      if (acc) sb.push_back(nxt);
      exp_valid = acc || (exp_valid && !fire);
    end
    #1;
    check("out_valid", 64'(b.out_valid), 64'(exp_valid));
    check("dec_count", 64'(dec_count), 64'(exp_cnt));
    if (exp_valid) check_rec(sb[0]);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [63:0] pc,
                       input logic rdy, input logic fl);
    b.in_valid  = v;
    b.in_inst   = w;
    b.in_pc     = pc;
    b.out_ready = rdy;
    b.flush     = fl;
  endtask

  logic [31:0] stream [12] = '{
    32'hCB020020, 32'h91000C41, 32'hD1000421, 32'hF8410020,
    32'hF81F83E1, 32'hB5000041, 32'h17FFFFFF, 32'h14000010,
    32'hAA0203E1, 32'h00000000, 32'h8A020020, 32'hFFFFFFFF
  };

  initial begin
    // Reset: outputs zero and no acceptance despite a valid offer.
    rst_n = 1'b0;
    drive(1'b1, 32'h8B020023, 64'h0, 1'b1, 1'b0);
    #3;
    check("rst_out_valid", 64'(b.out_valid), 64'd0);
    check("rst_dec_count", 64'(dec_count), 64'd0);
    check("rst_in_ready",  64'(b.in_ready), 64'd0);
    check("rst_out_imm",   b.out_imm, 64'd0);
    check("rst_out_fmt",   64'(b.out_fmt), 64'd0);
    tick();
    rst_n = 1'b1;

    // ADD, accepted on the first edge after reset release.
    drive(1'b1, 32'h8B020023, 64'h40, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("add_fmt", 64'(b.out_fmt), 64'd0);
    check("add_rd",  64'(b.out_rd),  64'd3);
    check("add_rn",  64'(b.out_rn),  64'd1);
    check("add_rm",  64'(b.out_rm),  64'd2);
    check("add_imm", b.out_imm, 64'd0);
    tick();
    check("add_count", 64'(dec_count), 64'd1);

    // CBZ with negative offset.
    drive(1'b1, 32'hB4FFFFC5, 64'h100, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("cbz_fmt",    64'(b.out_fmt), 64'd3);
    check("cbz_rd",     64'(b.out_rd),  64'd5);
    check("cbz_imm",    b.out_imm,      64'hFFFF_FFFF_FFFF_FFF8);
    check("cbz_target", b.out_target,   64'hF8);
    tick();

    // Illegal word: delivered, fields zero, not counted.
    drive(1'b1, 32'h00000000, 64'h200, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("ill_flag", 64'(b.out_illegal), 64'd1);
    check("ill_fmt",  64'(b.out_fmt),     64'd7);
    tick();
    check("ill_count", 64'(dec_count), 64'd2);

    // Flush while FULL with a new offer and out_ready high.
    drive(1'b1, 32'h8A020020, 64'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hAA0203E1, 64'h304, 1'b1, 1'b1);
    tick();
    check("flush_valid", 64'(b.out_valid), 64'd0);
    check("flush_count", 64'(dec_count), 64'd2);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    tick();

    // Backpressure: second word waits three cycles, then follows with no bubble.
    drive(1'b1, 32'hCB020020, 64'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hAA0203E1, 64'h404, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("bp_held_opcode", 64'(b.out_opcode), 64'(11'b11001011000));
    check("bp_count", 64'(dec_count), 64'd2);
    b.out_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("bp_second_opcode", 64'(b.out_opcode), 64'(11'b10101010000));
    tick();

    // Back-to-back stream across all formats; counter saturates at 3.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, stream[i], 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    tick();
    check("sat_count", 64'(dec_count), 64'd3);

    // Asynchronous reset between edges while FULL.
    drive(1'b1, 32'h14000010, 64'h2000, 1'b0, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",    64'(b.out_valid), 64'd0);
    check("arst_count",    64'(dec_count), 64'd0);
    check("arst_in_ready", 64'(b.in_ready), 64'd0);
    check("arst_imm",      b.out_imm, 64'd0);
    check("arst_target",   b.out_target, 64'd0);
    check("arst_opcode",   64'(b.out_opcode), 64'd0);
    exp_valid = 1'b0; exp_cnt = 0; sb.delete();
    rst_n = 1'b1;

    // First transfer after reset is accepted and counted.
    drive(1'b1, 32'h8B020023, 64'h40, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    tick();
    check("post_rst_count", 64'(dec_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
